// File: rtl/reduce_pkg.sv
// Shared definitions for the reducer accumulate/drain sequencer.
package reduce_pkg;

  typedef enum logic [2:0] {
    S_ACC   = 3'd0,
    S_FWAIT = 3'd1,
    S_DRD   = 3'd2,
    S_DOUT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int STATE_W = 3;

  function automatic int reduce_depth(input int log_depth);
    return 1 << log_depth;
  endfunction

endpackage

// File: rtl/reduce_fwd_stage.sv
// Accumulate stage: adds the registered beat to the BRAM read data, forwarding
// the previous cycle's write when it targets the same key (BRAM returns old data).
module reduce_fwd_stage #(
  parameter int W = 32,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         beat_valid,
  input  logic [K-1:0] beat_key,
  input  logic [W-1:0] beat_value,
  input  logic [W-1:0] rdata,
  output logic         wen,
  output logic [K-1:0] waddr,
  output logic [W-1:0] wdata,
  output logic         carry
);

  logic         s1_valid;
  logic [K-1:0] s1_key;
  logic [W-1:0] s1_value;
  logic         last_wen;
  logic [K-1:0] last_key;
  logic [W-1:0] last_data;
  logic [W-1:0] base;
  logic [W:0]   sum;

  always_comb begin
    base = rdata;
    if (last_wen && (last_key == s1_key)) begin
      base = last_data;
    end
    sum = {1'b0, base} + {1'b0, s1_value};
  end

  assign wen   = s1_valid;
  assign waddr = s1_key;
  assign wdata = sum[W-1:0];
  assign carry = s1_valid & sum[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_key    <= '0;
      s1_value  <= '0;
      last_wen  <= 1'b0;
      last_key  <= '0;
      last_data <= '0;
    end else begin
      s1_valid <= beat_valid;
      if (beat_valid) begin
        s1_key   <= beat_key;
        s1_value <= beat_value;
      end
      last_wen <= s1_valid;
      if (s1_valid) begin
        last_key  <= s1_key;
        last_data <= sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/reduce_accum_ctrl.sv
// Read-modify-write sequencer for the reducer BRAM: accumulates (key,value) beats,
// then on flush sweeps the table, emits non-zero sums and re-zeroes each entry.
module reduce_accum_ctrl
  import reduce_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_DEPTH = 2,
  parameter bit C_SKIP_ZERO = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [C_LOG_DEPTH-1:0] i_key,
  input  logic [C_WIDTH-1:0]     i_value,
  input  logic                   i_flush,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [C_LOG_DEPTH-1:0] o_out_key,
  output logic [C_WIDTH-1:0]     o_out_data,
  output logic                   o_flush_done,
  output logic                   o_ovf,
  output logic [C_LOG_DEPTH-1:0] o_raddr,
  output logic                   o_ce,
  input  logic [C_WIDTH-1:0]     i_rdata,
  output logic [C_LOG_DEPTH-1:0] o_waddr,
  output logic                   o_wen,
  output logic [C_WIDTH-1:0]     o_wdata,
  output logic [STATE_W-1:0]     o_state
);

  localparam int DEPTH = reduce_depth(C_LOG_DEPTH);
  localparam logic [C_LOG_DEPTH-1:0] LAST_ADDR = C_LOG_DEPTH'(DEPTH - 1);

  // Both streams use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a raised valid holds its payload until then.
  state_t                 state, state_nx;
  logic [C_LOG_DEPTH-1:0] addr, addr_nx;
  logic                   run;
  logic                   ovf;
  logic                   accept;
  logic                   zero_skip;
  logic                   drain_wen;
  logic                   ovf_clr;
  logic                   fwd_wen;
  logic                   fwd_carry;
  logic [C_LOG_DEPTH-1:0] fwd_waddr;
  logic [C_WIDTH-1:0]     fwd_wdata;

  assign o_ready    = run && (state == S_ACC);
  assign accept     = i_valid && o_ready;
  assign o_out_key  = addr;
  assign o_out_data = i_rdata;
  assign o_ovf      = ovf;
  assign o_state    = state;

  reduce_fwd_stage #(
    .W(C_WIDTH),
    .K(C_LOG_DEPTH)
  ) u_fwd (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .beat_valid(accept),
    .beat_key  (i_key),
    .beat_value(i_value),
    .rdata     (i_rdata),
    .wen       (fwd_wen),
    .waddr     (fwd_waddr),
    .wdata     (fwd_wdata),
    .carry     (fwd_carry)
  );

  // Accumulate writes only exist in S_ACC/S_FWAIT, drain writes only in S_DOUT.
  assign o_wen   = fwd_wen | drain_wen;
  assign o_waddr = fwd_wen ? fwd_waddr : addr;
  assign o_wdata = fwd_wen ? fwd_wdata : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_ACC;
      addr  <= '0;
      run   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      addr  <= addr_nx;
      run   <= 1'b1;
      if (ovf_clr) begin
        ovf <= 1'b0;
      end else if (fwd_carry) begin
        ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    o_ce         = 1'b0;
    o_raddr      = i_key;
    o_out_valid  = 1'b0;
    o_flush_done = 1'b0;
    zero_skip    = 1'b0;
    drain_wen    = 1'b0;
    ovf_clr      = 1'b0;
    case (state)
      S_ACC: begin
        o_ce = accept;
        if (i_flush) begin
          state_nx = S_FWAIT;
        end
      end
      S_FWAIT: begin
        state_nx = S_DRD;
      end
      S_DRD: begin
        o_ce     = 1'b1;
        o_raddr  = addr;
        state_nx = S_DOUT;
      end
      S_DOUT: begin
        // Read port is idle here, so i_rdata stays stable while stalled.
        zero_skip   = C_SKIP_ZERO && (i_rdata == '0);
        o_out_valid = !zero_skip;
        if (zero_skip || i_out_ready) begin
          drain_wen = 1'b1;
          if (addr == LAST_ADDR) begin
            state_nx = S_DONE;
          end else begin
            addr_nx  = addr + C_LOG_DEPTH'(1);
            state_nx = S_DRD;
          end
        end
      end
      S_DONE: begin
        o_flush_done = 1'b1;
        addr_nx      = '0;
        ovf_clr      = 1'b1;
        state_nx     = S_ACC;
      end
      default: begin
        state_nx = S_ACC;
      end
    endcase
  end

endmodule
